// File: rtl/seg7_num_disp.sv
// Binary-to-7-segment display driver: decimal (double dabble, optional sign) or hex,
// with leading-zero blanking and overflow indication. Segments are active-low.
module seg7_num_disp #(
    parameter int W       = 8,
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W-1:0]           din,
    input  logic                   load,
    input  logic                   signed_en,
    input  logic                   hex_mode,
    input  logic                   blank_en,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf,
    output logic [7*NDIGITS-1:0]   seg,
    output logic [1:0]             state_dbg
);
    // Handshake: load is taken on a rising edge only while busy=0; done pulses for
    // exactly the one cycle following the edge that writes seg/ovf.

    // Decimal digits needed for a W-bit magnitude: floor(W*log10(2)) + 1.
    localparam int BD   = W * 301 / 1000 + 1;
    localparam int HD   = (W + 3) / 4;
    localparam int MAXD = (BD > HD) ? BD : HD;
    localparam int DW   = 4 * MAXD;
    localparam int PD   = (MAXD > NDIGITS) ? MAXD : NDIGITS;

    localparam logic [6:0] GLYPH_MINUS = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FMT  = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    bin;
    logic [DW-1:0]   dig;
    logic            neg;
    logic            blank_r;
    logic [5:0]      cnt;

    logic [W-1:0]    mag;
    logic            neg_in;
    logic [DW-1:0]   dd;
    logic [DW-1:0]   dd_next;
    logic [4*PD-1:0] dig_pad;
    int              k_c;
    logic            ovf_c;
    logic [6:0]      lit;
    logic [3:0]      d;
    logic [7*NDIGITS-1:0] seg_c;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b0111111;
            4'h1: glyph = 7'b0000110;
            4'h2: glyph = 7'b1011011;
            4'h3: glyph = 7'b1001111;
            4'h4: glyph = 7'b1100110;
            4'h5: glyph = 7'b1101101;
            4'h6: glyph = 7'b1111101;
            4'h7: glyph = 7'b0000111;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1101111;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b1111100;
            4'hC: glyph = 7'b0111001;
            4'hD: glyph = 7'b1011110;
            4'hE: glyph = 7'b1111001;
            default: glyph = 7'b1110001;
        endcase
    endfunction

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        neg_in = signed_en && !hex_mode && din[W-1];
        mag    = neg_in ? (~din + 1'b1) : din;
    end

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next bit.
    always_comb begin
        dd = dig;
        for (int i = 0; i < MAXD; i++) begin
            if (dd[4*i +: 4] >= 4'd5)
                dd[4*i +: 4] = dd[4*i +: 4] + 4'd3;
        end
        dd_next = {dd[DW-2:0], bin[W-1]};
    end

    always_comb begin
        dig_pad = (4*PD)'(dig);
        k_c = 1;
        for (int i = 0; i < MAXD; i++) begin
            if (dig[4*i +: 4] != 4'd0)
                k_c = i + 1;
        end
        ovf_c = (k_c > NDIGITS) || (neg && (k_c > NDIGITS - 1));
        lit   = 7'b0;
        d     = 4'd0;
        seg_c = '1;
        for (int i = 0; i < NDIGITS; i++) begin
            d = dig_pad[4*i +: 4];
            if (ovf_c)
                lit = GLYPH_MINUS;
            else if (blank_r) begin
                if (i < k_c)
                    lit = glyph(d);
                else if (neg && i == k_c)
                    lit = GLYPH_MINUS;
                else
                    lit = 7'b0;
            end else if (neg && i == NDIGITS - 1)
                lit = GLYPH_MINUS;
            else
                lit = glyph(d);
            seg_c[7*i +: 7] = ~lit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bin     <= '0;
            dig     <= '0;
            neg     <= 1'b0;
            blank_r <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            seg     <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        blank_r <= blank_en;
                        cnt     <= '0;
                        if (hex_mode) begin
                            dig   <= DW'(din);
                            neg   <= 1'b0;
                            state <= FMT;
                        end else begin
                            bin   <= mag;
                            dig   <= '0;
                            neg   <= neg_in;
                            state <= CONV;
                        end
                    end
                end
                CONV: begin
                    dig <= dd_next;
                    bin <= {bin[W-2:0], 1'b0};
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(W - 1))
                        state <= FMT;
                end
                FMT: begin
                    seg   <= seg_c;
                    ovf   <= ovf_c;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg7_num_disp.sv
// Directed bench for seg7_num_disp: W=8/NDIGITS=4 and W=8/NDIGITS=3 instances,
// expected displays queued at load time and checked by done-triggered monitors.
module tb_seg7_num_disp;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  a_din, b_din;
    logic        a_load, a_sg, a_hx, a_bl;
    logic        b_load, b_sg, b_hx, b_bl;
    logic        a_busy, a_done, a_ovf, b_busy, b_done, b_ovf;
    logic [27:0] a_seg;
    logic [20:0] b_seg;
    logic [1:0]  a_st, b_st;

    seg7_num_disp #(.W(8), .NDIGITS(4)) dut_a (
        .clk(clk), .rst(rst), .din(a_din), .load(a_load), .signed_en(a_sg),
        .hex_mode(a_hx), .blank_en(a_bl), .busy(a_busy), .done(a_done),
        .ovf(a_ovf), .seg(a_seg), .state_dbg(a_st)
    );

    seg7_num_disp #(.W(8), .NDIGITS(3)) dut_b (
        .clk(clk), .rst(rst), .din(b_din), .load(b_load), .signed_en(b_sg),
        .hex_mode(b_hx), .blank_en(b_bl), .busy(b_busy), .done(b_done),
        .ovf(b_ovf), .seg(b_seg), .state_dbg(b_st)
    );

    // Lit patterns gfedcba
    localparam logic [6:0] G0 = 7'b0111111, G1 = 7'b0000110, G2 = 7'b1011011;
    localparam logic [6:0] G3 = 7'b1001111, G4 = 7'b1100110, G5 = 7'b1101101;
    localparam logic [6:0] G8 = 7'b1111111, G9 = 7'b1101111, GA = 7'b1110111;
    localparam logic [6:0] GF = 7'b1110001, GM = 7'b1000000, GB = 7'b0000000;

    function automatic logic [27:0] d4(input logic [6:0] g3, g2, g1, g0);
        return ~{g3, g2, g1, g0};
    endfunction

    function automatic logic [20:0] d3(input logic [6:0] g2, g1, g0);
        return ~{g2, g1, g0};
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    logic [60:0] qa[$];   // {done cycle, ovf, seg}
    logic [53:0] qb[$];
    logic [27:0] a_prev = '1;
    logic [20:0] b_prev = '1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [60:0] e;
        if (a_done) begin
            if (qa.size() == 0)
                check("a_unexpected_done", a_done, 0);
            else begin
                e = qa.pop_front();
                check("a_done_cycle", cyc, e[60:29]);
                check("a_ovf", a_ovf, e[28]);
                check("a_seg", a_seg, e[27:0]);
            end
        end
    end

    always @(negedge clk) begin
        logic [53:0] e;
        if (b_done) begin
            if (qb.size() == 0)
                check("b_unexpected_done", b_done, 0);
            else begin
                e = qb.pop_front();
                check("b_done_cycle", cyc, e[53:22]);
                check("b_ovf", b_ovf, e[21]);
                check("b_seg", b_seg, e[20:0]);
            end
        end
    end

    // Call at a negedge; returns at the negedge where busy has dropped.
    task automatic issue_a(input logic [7:0] dv, input logic sg, hx, bl,
                           input logic [27:0] es, input logic eo, input bit poke);
        int n, lat, busy_cnt, budget;
        a_din = dv; a_sg = sg; a_hx = hx; a_bl = bl; a_load = 1'b1;
        n   = cyc + 1;
        lat = hx ? 1 : 9;
        qa.push_back({32'(n + lat), eo, es});
        @(negedge clk);
        a_load = 1'b0;
        busy_cnt = 0;
        budget   = 0;
        while (a_busy && budget < 100) begin
            if (busy_cnt == 0)
                check("a_seg_hold", a_seg, a_prev);
            busy_cnt++;
            if (poke && cyc == n + 2) begin
                a_load = 1'b1; a_din = 8'h11; a_hx = 1'b1; a_bl = 1'b0;
            end else
                a_load = 1'b0;
            @(negedge clk);
            budget++;
        end
        a_load = 1'b0;
        check("a_busy_cycles", busy_cnt, lat);
        a_prev = es;
    endtask

    task automatic issue_b(input logic [7:0] dv, input logic sg, hx, bl,
                           input logic [20:0] es, input logic eo);
        int n, lat, busy_cnt, budget;
        b_din = dv; b_sg = sg; b_hx = hx; b_bl = bl; b_load = 1'b1;
        n   = cyc + 1;
        lat = hx ? 1 : 9;
        qb.push_back({32'(n + lat), eo, es});
        @(negedge clk);
        b_load = 1'b0;
        busy_cnt = 0;
        budget   = 0;
        while (b_busy && budget < 100) begin
            if (busy_cnt == 0)
                check("b_seg_hold", b_seg, b_prev);
            busy_cnt++;
            @(negedge clk);
            budget++;
        end
        check("b_busy_cycles", busy_cnt, lat);
        b_prev = es;
    endtask

    task automatic abort_a();
        int n;
        a_din = 8'hFF; a_sg = 1'b0; a_hx = 1'b0; a_bl = 1'b1; a_load = 1'b1;
        n = cyc + 1;
        @(negedge clk);
        a_load = 1'b0;
        for (int i = 0; i < 20 && cyc < n + 3; i++) @(negedge clk);
        check("abort_mid_conv_busy", a_busy, 1);
        rst = 1'b1;
        #1;
        check("abort_seg_blank", a_seg, 28'hFFFFFFF);
        check("abort_busy", a_busy, 0);
        check("abort_done", a_done, 0);
        check("abort_ovf", a_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        a_prev = '1;
        b_prev = '1;
        repeat (12) @(negedge clk);
        check("abort_idle", a_busy, 0);
        check("abort_seg_kept_blank", a_seg, 28'hFFFFFFF);
    endtask

    initial begin
        rst = 1'b1;
        a_din = '0; a_load = 1'b0; a_sg = 1'b0; a_hx = 1'b0; a_bl = 1'b0;
        b_din = '0; b_load = 1'b0; b_sg = 1'b0; b_hx = 1'b0; b_bl = 1'b0;
        #1;
        check("reset_seg_a", a_seg, 28'hFFFFFFF);
        check("reset_seg_b", b_seg, 21'h1FFFFF);
        check("reset_busy", a_busy, 0);
        check("reset_done", a_done, 0);
        check("reset_ovf", a_ovf, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue_a(8'hFF, 0, 0, 1, d4(GB, G2, G5, G5), 0, 0);
        issue_a(8'h80, 1, 0, 1, d4(GM, G1, G2, G8), 0, 0);
        issue_a(8'hFF, 1, 0, 1, d4(GB, GB, GM, G1), 0, 0);
        issue_a(8'h00, 0, 0, 1, d4(GB, GB, GB, G0), 0, 0);
        issue_a(8'h00, 0, 0, 0, d4(G0, G0, G0, G0), 0, 0);
        issue_a(8'hAF, 0, 1, 1, d4(GB, GB, GA, GF), 0, 0);
        issue_a(8'hAF, 1, 1, 0, d4(G0, G0, GA, GF), 0, 0);
        issue_a(8'h00, 0, 1, 1, d4(GB, GB, GB, G0), 0, 0);
        issue_a(8'h85, 1, 0, 0, d4(GM, G1, G2, G3), 0, 0);
        issue_a(8'hC8, 0, 0, 0, d4(G0, G2, G0, G0), 0, 0);
        issue_a(8'h0A, 1, 0, 1, d4(GB, GB, G1, G0), 0, 0);
        issue_a(8'h7B, 0, 0, 1, d4(GB, G1, G2, G3), 0, 1);
        check("ignored_load_idle", a_busy, 0);

        abort_a();
        issue_a(8'h2A, 0, 0, 0, d4(G0, G0, G4, G2), 0, 0);

        issue_b(8'h9C, 1, 0, 1, d3(GM, GM, GM), 1);
        issue_b(8'h05, 1, 0, 1, d3(GB, GB, G5), 0);
        issue_b(8'h9D, 1, 0, 1, d3(GM, G9, G9), 0);
        issue_b(8'hFF, 0, 0, 0, d3(G2, G5, G5), 0);

        for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_num_disp.md
SEG7_NUM_DISP -- requirements
Module: seg7_num_disp

Interface
REQ-001 Parameter W, default 8: input value width, 4..32.
REQ-002 Parameter NDIGITS, default 4: number of 7-segment digits, 1..10.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 din  input  W  value to display; sampled only on an accepted load.
REQ-006 load  input  1  request to convert din; accepted when busy=0.
REQ-007 signed_en  input  1  decimal mode only: 1 = din is two's complement; sampled with din.
REQ-008 hex_mode  input  1  1 = hexadecimal display, 0 = decimal; sampled with din.
REQ-009 blank_en  input  1  1 = leading-zero blanking; sampled with din.
REQ-010 busy  output  1  conversion in progress.
REQ-011 done  output  1  one-cycle pulse on the edge that updates seg.
REQ-012 ovf  output  1  last completed value did not fit in NDIGITS; held until next update.
REQ-013 seg  output  7*NDIGITS  active-low segments, digit i at seg[7i+6:7i], bit order g f e d c b a; digit 0 rightmost.

Function
REQ-014 Glyphs, shown as lit bits gfedcba and inverted on output:
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
- 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- minus=1000000, blank=0000000
REQ-015 FSM states: IDLE, CONV, FMT; busy=1 in CONV and FMT, 0 in IDLE.
REQ-016 IDLE: load=1 at edge N latches din/mode inputs; next state is CONV for decimal, FMT for hex.
REQ-017 Decimal magnitude: din if signed_en=0 or din[W-1]=0, else (-din) mod 2^W as an unsigned W-bit value (-2^(W-1) yields 2^(W-1)); negative flag set accordingly.
REQ-018 CONV: shift-add-3 (double dabble), one bit per cycle MSB first, exactly W cycles; then FMT.
REQ-019 FMT: one cycle; on its closing edge seg, ovf and done=1 are written and state returns to IDLE.
REQ-020 Latency: decimal, seg/done update on edge N+W+1; hex, on edge N+1; load accepted on edge N.
REQ-021 load while busy=1 is ignored and not queued; din/mode changes during busy have no effect.
REQ-022 seg holds the previous display unchanged throughout busy; update is atomic over all digits.
REQ-023 Hex mode: digit i = nibble i of din (zero-extended to 4*NDIGITS); signed_en ignored; no sign glyph.
REQ-024 Significant digits: k = position of highest nonzero digit + 1, minimum 1 (value 0 shows a single "0" in digit 0).
REQ-025 blank_en=1: digits >= k blank; if negative, minus in digit k, digits above blank.
REQ-026 blank_en=0: all NDIGITS digits shown with leading zeros; if negative, minus in digit NDIGITS-1.
REQ-027 Overflow: ovf=1 if k > NDIGITS, or if negative and k > NDIGITS-1; then every digit shows minus.
REQ-028 done is never asserted outside the FMT exit edge; back-to-back load accepted on the cycle after done.

Reset
REQ-029 rst=1 forces immediately, regardless of clk: state IDLE, busy=0, done=0, ovf=0, every digit blank (all seg bits 1).
REQ-030 rst during CONV/FMT aborts conversion; no done pulse; no seg update; first load after rst release is accepted normally.

Verification (W=8, NDIGITS=4 unless stated)
REQ-031 Decimal, din=0xFF, signed_en=0, blank_en=1 -> at load+9: digits 3..0 = blank,2,5,5; done pulse 1 cycle; ovf=0.
REQ-032 Decimal, din=0x80, signed_en=1, blank_en=1 -> minus,1,2,8; din=0xFF signed -> blank,blank,minus,1.
REQ-033 Decimal, din=0, blank_en=1 -> blank,blank,blank,0; blank_en=0 -> 0,0,0,0.
REQ-034 Hex, din=0xAF, blank_en=1 -> at load+1: blank,blank,A,F; busy high exactly 1 cycle.
REQ-035 load pulsed at load+3 during decimal conversion -> ignored, single done at load+9; rst at load+4 -> seg all blank, no done.
REQ-036 NDIGITS=3, decimal signed din=0x9C (-100) -> ovf=1, all three digits minus; next din=0x05 -> ovf=0.
